// File: rtl/srm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : srm_pkg
//  Description : Shared constants for the simple RISC controller: opcode and
//                op-field codes, FSM state encoding and writeback mux codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package srm_pkg;

  // Instruction field widths
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  // Opcode field [15:13]
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // op field [12:11] under OP_MOV
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // op field [12:11] under OP_ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Controller state encoding
  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_GETA   = 3'd2;
  localparam logic [2:0] S_GETB   = 3'd3;
  localparam logic [2:0] S_ALU    = 3'd4;
  localparam logic [2:0] S_WREG   = 3'd5;
  localparam logic [2:0] S_WIMM   = 3'd6;

  // Writeback source select
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  // True for MOV Rn,#imm8
  function automatic logic is_movi(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OP_MOV) && (op == MOV_IMM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/srm_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : srm_decoder
//  Description : Combinational field extraction and sign extension of the
//                latched instruction word.
//  Revision    : 1.0 - initial release
// ============================================================================
module srm_decoder
  import srm_pkg::*;
(
  input  logic [DATA_W-1:0] i_instr,
  output logic [2:0]        o_opcode,
  output logic [1:0]        o_op,
  output logic [REG_W-1:0]  o_rn,
  output logic [REG_W-1:0]  o_rd,
  output logic [REG_W-1:0]  o_rm,
  output logic [1:0]        o_shift,
  output logic [DATA_W-1:0] o_sximm8,
  output logic [DATA_W-1:0] o_sximm5
);

  // Field slicing; the shift field is meaningless for MOV immediate, so it is
  // forced to "no shift" there to keep the datapath shifter idle.
  always_comb begin
    o_opcode = i_instr[15:13];
    o_op     = i_instr[12:11];
    o_rn     = i_instr[10:8];
    o_rd     = i_instr[7:5];
    o_rm     = i_instr[2:0];
    o_shift  = is_movi(i_instr[15:13], i_instr[12:11]) ? 2'b00 : i_instr[4:3];
    o_sximm8 = {{(DATA_W-8){i_instr[7]}}, i_instr[7:0]};
    o_sximm5 = {{(DATA_W-5){i_instr[4]}}, i_instr[4:0]};
  end

endmodule
`default_nettype wire

// File: rtl/srm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : srm_controller
//  Description : Instruction register and Moore control FSM sequencing the
//                register file and datapath strobes of the simple RISC core.
//  Revision    : 1.0 - initial release
// ============================================================================
module srm_controller
  import srm_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              s,
  input  logic [DATA_W-1:0] in,
  output logic              w,
  output logic [REG_W-1:0]  readnum,
  output logic [REG_W-1:0]  writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5
);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [DATA_W-1:0] r_instr;

  logic [2:0]        w_opcode;
  logic [1:0]        w_op;
  logic [REG_W-1:0]  w_rn;
  logic [REG_W-1:0]  w_rd;
  logic [REG_W-1:0]  w_rm;

  logic              w_idle;
  logic              w_is_cmp;
  logic              w_is_mov_type;

  srm_decoder u_decoder (
    .i_instr  (r_instr),
    .o_opcode (w_opcode),
    .o_op     (w_op),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_rm     (w_rm),
    .o_shift  (shift),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5)
  );

  assign w_idle        = (r_state == S_WAIT);
  assign w_is_cmp      = (w_opcode == OP_ALU) && (w_op == ALU_CMP);
  // MOV reg and MVN have no A operand; the ALU sees zero on that side.
  assign w_is_mov_type = ((w_opcode == OP_MOV) && (w_op == MOV_REG)) ||
                         ((w_opcode == OP_ALU) && (w_op == ALU_MVN));
  assign ALUop         = w_op;

  // Instruction register: only accepts a new word while idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_instr <= '0;
    end else if (load && w_idle) begin
      r_instr <= in;
    end
  end

  // State register; reset lands in WAIT so any in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = S_WAIT;
    case (r_state)
      S_WAIT:   w_next_state = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (is_movi(w_opcode, w_op)) begin
          w_next_state = S_WIMM;
        end else if (w_opcode == OP_MOV && w_op == MOV_REG) begin
          w_next_state = S_GETB;
        end else if (w_opcode == OP_ALU) begin
          w_next_state = (w_op == ALU_MVN) ? S_GETB : S_GETA;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_GETA:   w_next_state = S_GETB;
      S_GETB:   w_next_state = S_ALU;
      S_ALU:    w_next_state = w_is_cmp ? S_WAIT : S_WREG;
      S_WREG:   w_next_state = S_WAIT;
      S_WIMM:   w_next_state = S_WAIT;
      default:  w_next_state = S_WAIT;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    case (r_state)
      S_WAIT: w = 1'b1;
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        asel  = w_is_mov_type;
        loads = w_is_cmp;
      end
      S_WREG: begin
        writenum = w_rd;
        write    = 1'b1;
        vsel     = VSEL_C;
      end
      S_WIMM: begin
        writenum = w_rn;
        write    = 1'b1;
        vsel     = VSEL_IMM8;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_srm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srm_controller
//  Description : Directed self-checking bench for srm_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srm_controller;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada, loadb, loadc, loads;
  logic        asel, bsel;
  logic [1:0]  vsel;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  int checks = 0;
  int errors = 0;

  srm_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .s        (s),
    .in       (in),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .ALUop    (ALUop),
    .shift    (shift),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare observed against expected and count the outcome.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobes packed as {loada,loadb,loadc,loads}.
  function automatic logic [3:0] strobes();
    return {loada, loadb, loadc, loads};
  endfunction

  task automatic issue(input logic [15:0] instr);
    load = 1'b1; s = 1'b1; in = instr;
    step();
    load = 1'b0; s = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0000;
    step();
    check("rst_w", w, 1);
    check("rst_write", write, 0);
    check("rst_strobes", strobes(), 4'b0000);
    check("rst_sximm8", sximm8, 16'h0000);
    reset_n = 1'b1;
    step();

    // MOVI R2,#7
    issue(16'hD207);
    check("movi_dec_w", w, 0);
    check("movi_dec_write", write, 0);
    step();
    check("movi_wimm_writenum", writenum, 2);
    check("movi_wimm_write", write, 1);
    check("movi_wimm_vsel", vsel, 2'b10);
    check("movi_wimm_sximm8", sximm8, 16'h0007);
    check("movi_wimm_sximm5", sximm5, 16'h0007);
    step();
    check("movi_done_w", w, 1);
    check("movi_done_write", write, 0);

    // MOVI R4,#-10 : negative immediate, shift field forced to 00
    issue(16'hD4F6);
    step();
    check("movin_sximm8", sximm8, 16'hFFF6);
    check("movin_writenum", writenum, 4);
    check("movin_shift", shift, 2'b00);
    check("movin_sximm5", sximm5, 16'hFFF6);
    step();
    check("movin_done_w", w, 1);

    // ADD R3,R1,R0 LSL#1 with busy-time load/s that must be ignored
    issue(16'hA168);
    step();
    check("add_geta_readnum", readnum, 1);
    check("add_geta_strobes", strobes(), 4'b1000);
    load = 1'b1; s = 1'b1; in = 16'hD3FF;
    step();
    check("add_getb_readnum", readnum, 0);
    check("add_getb_strobes", strobes(), 4'b0100);
    step();
    load = 1'b0; s = 1'b0;
    check("add_alu_strobes", strobes(), 4'b0010);
    check("add_alu_aluop", ALUop, 2'b00);
    check("add_alu_shift", shift, 2'b01);
    check("add_alu_asel", asel, 0);
    check("add_ir_kept", sximm8, 16'h0068);
    step();
    check("add_wreg_writenum", writenum, 3);
    check("add_wreg_write", write, 1);
    check("add_wreg_vsel", vsel, 2'b00);
    step();
    check("add_done_w", w, 1);

    // CMP R1,R1 : status only, never writes
    issue(16'hA901);
    check("cmp_dec_write", write, 0);
    step();
    check("cmp_geta_write", write, 0);
    step();
    check("cmp_getb_write", write, 0);
    step();
    check("cmp_alu_strobes", strobes(), 4'b0011);
    check("cmp_alu_aluop", ALUop, 2'b01);
    check("cmp_alu_write", write, 0);
    step();
    check("cmp_done_w", w, 1);
    check("cmp_done_write", write, 0);

    // MVN R5,R2 : skips GETA, zero A operand
    issue(16'hB8A2);
    step();
    check("mvn_getb_readnum", readnum, 2);
    check("mvn_getb_strobes", strobes(), 4'b0100);
    step();
    check("mvn_alu_asel", asel, 1);
    check("mvn_alu_aluop", ALUop, 2'b11);
    check("mvn_alu_strobes", strobes(), 4'b0010);
    step();
    check("mvn_wreg_writenum", writenum, 5);
    check("mvn_wreg_write", write, 1);
    step();
    check("mvn_done_w", w, 1);

    // Reset mid-ADD while in GETB
    issue(16'hA168);
    step();
    step();
    check("abort_getb_loadb", loadb, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("abort_w", w, 1);
    check("abort_write", write, 0);
    check("abort_strobes", strobes(), 4'b0000);
    check("abort_ir_cleared", sximm8, 16'h0000);
    // Start with no load: IR=0000 is illegal, back to WAIT without writing
    s = 1'b1;
    step();
    s = 1'b0;
    check("illegal_dec_w", w, 0);
    check("illegal_dec_write", write, 0);
    step();
    check("illegal_done_w", w, 1);
    check("illegal_done_write", write, 0);

    // s held high restarts MOVI from WAIT on the next edge
    issue(16'hD207);
    s = 1'b1;
    step();
    check("hold_wimm_write", write, 1);
    step();
    check("hold_wait_w", w, 1);
    step();
    check("hold_restart_w", w, 0);
    s = 1'b0;
    step();
    check("hold_restart_wimm", write, 1);
    step();
    check("hold_final_w", w, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/srm_controller.md
Name: srm_controller

Overview:
- Instruction register plus control FSM for the simple RISC datapath.
- Latches a 16-bit instruction, decodes it, and sequences the register file's readnum/writenum/write and the datapath load strobes and muxes.
- Sits directly upstream of the register file: it is the only driver of its readnum, writenum and write inputs.

Parameters:
- none (data width fixed at 16, register address width fixed at 3)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous reset, active-low
- load  in  1  latch `in` into the instruction register (honoured only while w=1)
- s  in  1  start execution of the latched instruction (honoured only while w=1)
- in  in  16  instruction word
- w  out  1  1 = idle (WAIT state)
- readnum  out  3  register file read address
- writenum  out  3  register file write address
- write  out  1  register file write enable
- loada, loadb, loadc, loads  out  1 each  datapath A/B/C/status load strobes
- asel, bsel  out  1 each  1 = zero A input / 1 = sximm5 on B input
- vsel  out  2  writeback source: 00 = C, 10 = sximm8; 01 and 11 are never driven
- ALUop  out  2  instruction bits [12:11]
- shift  out  2  instruction bits [4:3]; forced to 00 for MOV immediate
- sximm8  out  16  sign-extended instruction bits [7:0]
- sximm5  out  16  sign-extended instruction bits [4:0]

Behaviour:
- Encoding: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0].
- Instruction set:
  - MOVI: 110/10, Rn <= sximm8
  - MOV: 110/00, Rd <= Rm shifted
  - ADD: 101/00
  - CMP: 101/01, status only
  - AND: 101/10
  - MVN: 101/11, Rd <= ~Rm shifted
- Instruction register updates on a clk edge when load=1 && w=1; load is ignored otherwise. ALUop, shift, sximm8 and sximm5 decode combinationally from the instruction register.
- States and transitions:
  - WAIT: -> DECODE when s=1.
  - DECODE: MOVI -> WIMM; ADD/CMP/AND -> GETA; MOV/MVN -> GETB; any other encoding -> WAIT with no write.
  - GETA -> GETB -> ALU.
  - ALU -> WAIT if CMP, else -> WREG.
  - WIMM -> WAIT; WREG -> WAIT.
- Moore outputs. Defaults in every state: all strobes 0, write 0, readnum 0, writenum 0, vsel 00, asel 0, bsel 0.
  - WAIT: w=1.
  - GETA: readnum=Rn, loada=1.
  - GETB: readnum=Rm, loadb=1.
  - ALU: loadc=1; asel=1 for MOV/MVN; loads=1 for CMP only.
  - WREG: writenum=Rd, write=1, vsel=00.
  - WIMM: writenum=Rn, write=1, vsel=10.
- The register file reads combinationally and writes on the clk edge that leaves WREG or WIMM.
- Latency from the s-sampling edge to w=1:
  - MOVI: 3 edges (DECODE, WIMM, WAIT).
  - CMP: 5 edges.
  - ADD/AND: 6 edges.
  - MOV/MVN: 5 edges.
- s held high continuously restarts the same instruction from WAIT on the next edge.
- s or load while busy: ignored, with no effect on state or instruction register.
- Reset (reset_n=0 at an edge, any state including mid-instruction):
  - state=WAIT, instruction register=16'h0000.
  - Outputs after that edge: w=1, write=0, all strobes 0.
  - An aborted write never occurs.

Decomposition:
- Package srm_pkg:
  - opcode/op constants (OP_MOV=3'b110, OP_ALU=3'b101, ALU_ADD/CMP/AND/MVN)
  - state encoding (WAIT, DECODE, GETA, GETB, ALU, WREG, WIMM)
  - vsel codes (VSEL_C=2'b00, VSEL_IMM8=2'b10)
- Sub-module srm_decoder: combinational field extraction and sign extension (sximm8, sximm5, Rn/Rd/Rm, ALUop, shift). The FSM and instruction register stay in srm_controller.

Test Plan:
- Reset with reset_n=0 while in GETB of an ADD -> after the edge: w=1, write=0, all strobes 0; a subsequent s with no load decodes 16'h0000 as illegal and returns to WAIT with write never asserted.
- load in=16'hD207 (MOVI R2,#7), pulse s -> DECODE; then WIMM with writenum=2, write=1, vsel=10, sximm8=16'h0007; w=1 three edges after s.
- load 16'hD4F6 (MOVI R4,#-10) -> in WIMM sximm8=16'hFFF6, writenum=4.
- load 16'hA168 (ADD R3,R1,R0 LSL#1) -> GETA readnum=1 loada=1; GETB readnum=0 loadb=1; ALU loadc=1 ALUop=00 shift=01; WREG writenum=3 write=1.
- load 16'hA901 (CMP R1,R1) -> ALU loads=1 loadc=1 ALUop=01; returns to WAIT with write never asserted.
- Busy-ignore: during an ADD, drive load=1 with in=16'hD3FF and s=1 -> instruction register unchanged; the ADD completes with writenum=3.
